// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions: widths, opcode constants, control bundle layout and ALU op encodings.
package legv8_pkg;

  localparam int LEGV8_INTEGER_SZ     = 64;
  localparam int LEGV8_INSTRUCTION_SZ = 32;

  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [9:0]  OP_ADDI = 10'h244;
  localparam logic [9:0]  OP_SUBI = 10'h344;
  localparam logic [7:0]  OP_CBZ  = 8'hB4;
  localparam logic [5:0]  OP_B    = 6'h05;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_PASSB = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  typedef struct packed {
    logic    reg2loc;
    logic    alu_src;
    logic    mem_to_reg;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    uncond_branch;
    alu_op_e alu_op;
  } ctrl_t;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_R,
    FMT_I,
    FMT_D,
    FMT_CB,
    FMT_B
  } fmt_e;

endpackage

// File: rtl/register_file.sv
// 32 x DATA_W register file: two read ports, one synchronous write port, X31 reads zero,
// and a same-cycle write is visible on the read ports (write-first).
module register_file
  import legv8_pkg::*;
#(
  parameter int DATA_W = LEGV8_INTEGER_SZ
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        i_raddr1,
  input  logic [4:0]        i_raddr2,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2,
  input  logic              i_wen,
  input  logic [4:0]        i_waddr,
  input  logic [DATA_W-1:0] i_wdata
);

  logic [DATA_W-1:0] r_regs [32];
  logic              w_wr;

  assign w_wr = i_wen && (i_waddr != 5'd31);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (w_wr) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == 5'd31)            ? '0      :
                    (w_wr && i_waddr == i_raddr1)  ? i_wdata : r_regs[i_raddr1];
  assign o_rdata2 = (i_raddr2 == 5'd31)            ? '0      :
                    (w_wr && i_waddr == i_raddr2)  ? i_wdata : r_regs[i_raddr2];

endmodule

// File: rtl/stage2_decode.sv
// LEGv8 decode stage: decoder, register file, load-use interlock and the ID/EX register.
// Define LEGV8_HAZARD_DETECT_EN to build in the load-use interlock.
module stage2_decode
  import legv8_pkg::*;
#(
  parameter int DATA_W  = LEGV8_INTEGER_SZ,
  parameter int INSTR_W = LEGV8_INSTRUCTION_SZ
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [DATA_W-1:0]  in_pc,
  input  logic               flush,
  input  logic               wb_en,
  input  logic [4:0]         wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  input  logic               ex_mem_read,
  input  logic [4:0]         ex_rd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_pc,
  output logic [DATA_W-1:0]  out_rdata1,
  output logic [DATA_W-1:0]  out_rdata2,
  output logic [DATA_W-1:0]  out_imm,
  output logic [4:0]         out_rd,
  output logic [9:0]         out_ctrl,
  output logic               out_illegal
);

  logic [10:0]              w_op11;
  logic [9:0]               w_op10;
  logic [7:0]               w_op8;
  logic [5:0]               w_op6;
  ctrl_t                    w_ctrl;
  fmt_e                     w_fmt;
  logic                     w_illegal;
  logic                     w_use_rn;
  logic                     w_use_r2;
  logic [4:0]               w_rn_idx;
  logic [4:0]               w_r2_idx;
  logic signed [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0]        w_rdata1;
  logic [DATA_W-1:0]        w_rdata2;
  logic                     w_stall;
  logic                     w_accept;

  logic                     r_valid;
  logic [DATA_W-1:0]        r_pc;
  logic [DATA_W-1:0]        r_rdata1;
  logic [DATA_W-1:0]        r_rdata2;
  logic signed [DATA_W-1:0] r_imm;
  logic [4:0]               r_rd;
  ctrl_t                    r_ctrl;
  logic                     r_illegal;
  logic [4:0]               r_rn_idx;
  logic [4:0]               r_r2_idx;

  assign w_op11 = in_instr[31:21];
  assign w_op10 = in_instr[31:22];
  assign w_op8  = in_instr[31:24];
  assign w_op6  = in_instr[31:26];

  // Opcode fields have different widths per format; none of the encodings overlap.
  always_comb begin
    w_ctrl    = '0;
    w_fmt     = FMT_NONE;
    w_illegal = 1'b1;
    w_use_rn  = 1'b0;
    w_use_r2  = 1'b0;
    if (w_op11 == OP_ADD || w_op11 == OP_SUB || w_op11 == OP_AND || w_op11 == OP_ORR) begin
      w_fmt            = FMT_R;
      w_illegal        = 1'b0;
      w_ctrl.reg_write = 1'b1;
      w_ctrl.alu_op    = ALU_FUNCT;
      w_use_rn         = 1'b1;
      w_use_r2         = 1'b1;
    end else if (w_op11 == OP_LDUR) begin
      w_fmt             = FMT_D;
      w_illegal         = 1'b0;
      w_ctrl.alu_src    = 1'b1;
      w_ctrl.mem_to_reg = 1'b1;
      w_ctrl.reg_write  = 1'b1;
      w_ctrl.mem_read   = 1'b1;
      w_ctrl.alu_op     = ALU_ADD;
      w_use_rn          = 1'b1;
    end else if (w_op11 == OP_STUR) begin
      w_fmt            = FMT_D;
      w_illegal        = 1'b0;
      w_ctrl.reg2loc   = 1'b1;
      w_ctrl.alu_src   = 1'b1;
      w_ctrl.mem_write = 1'b1;
      w_ctrl.alu_op    = ALU_ADD;
      w_use_rn         = 1'b1;
      w_use_r2         = 1'b1;
    end else if (w_op10 == OP_ADDI || w_op10 == OP_SUBI) begin
      w_fmt            = FMT_I;
      w_illegal        = 1'b0;
      w_ctrl.alu_src   = 1'b1;
      w_ctrl.reg_write = 1'b1;
      w_ctrl.alu_op    = ALU_FUNCT;
      w_use_rn         = 1'b1;
    end else if (w_op8 == OP_CBZ) begin
      w_fmt          = FMT_CB;
      w_illegal      = 1'b0;
      w_ctrl.reg2loc = 1'b1;
      w_ctrl.branch  = 1'b1;
      w_ctrl.alu_op  = ALU_PASSB;
      w_use_r2       = 1'b1;
    end else if (w_op6 == OP_B) begin
      w_fmt                = FMT_B;
      w_illegal            = 1'b0;
      w_ctrl.uncond_branch = 1'b1;
      w_ctrl.alu_op        = ALU_ADD;
    end
  end

  always_comb begin
    w_imm = '0;
    case (w_fmt)
      FMT_I:   w_imm = {{(DATA_W-12){1'b0}}, in_instr[21:10]};
      FMT_D:   w_imm = {{(DATA_W-9){in_instr[20]}}, in_instr[20:12]};
      FMT_CB:  w_imm = {{(DATA_W-21){in_instr[23]}}, in_instr[23:5], 2'b00};
      FMT_B:   w_imm = {{(DATA_W-28){in_instr[25]}}, in_instr[25:0], 2'b00};
      default: w_imm = '0;
    endcase
  end

  assign w_rn_idx = in_instr[9:5];
  assign w_r2_idx = w_ctrl.reg2loc ? in_instr[4:0] : in_instr[20:16];

  register_file #(
    .DATA_W (DATA_W)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .i_raddr1 (w_rn_idx),
    .i_raddr2 (w_r2_idx),
    .o_rdata1 (w_rdata1),
    .o_rdata2 (w_rdata2),
    .i_wen    (wb_en),
    .i_waddr  (wb_addr),
    .i_wdata  (wb_data)
  );

`ifdef LEGV8_HAZARD_DETECT_EN
  assign w_stall = ex_mem_read && (ex_rd != 5'd31) &&
                   ((w_use_rn && ex_rd == w_rn_idx) || (w_use_r2 && ex_rd == w_r2_idx));
`else
  logic w_unused_hazard;
  assign w_unused_hazard = ^{ex_mem_read, ex_rd, w_use_rn, w_use_r2};
  assign w_stall         = 1'b0;
`endif

  assign in_ready = !reset && !flush && !w_stall && (!r_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  // ID/EX register boundary
  always_ff @(posedge clk) begin
    if (reset)         r_valid <= 1'b0;
    else if (flush)    r_valid <= 1'b0;
    else if (w_accept) r_valid <= 1'b1;
    else if (out_ready) r_valid <= 1'b0;
  end

  // A held bundle keeps tracking write-backs so its operands are never stale when consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc      <= '0;
      r_rdata1  <= '0;
      r_rdata2  <= '0;
      r_imm     <= '0;
      r_rd      <= '0;
      r_ctrl    <= '0;
      r_illegal <= 1'b0;
      r_rn_idx  <= '0;
      r_r2_idx  <= '0;
    end else if (w_accept) begin
      r_pc      <= in_pc;
      r_rdata1  <= w_rdata1;
      r_rdata2  <= w_rdata2;
      r_imm     <= w_imm;
      r_rd      <= in_instr[4:0];
      r_ctrl    <= w_ctrl;
      r_illegal <= w_illegal;
      r_rn_idx  <= w_rn_idx;
      r_r2_idx  <= w_r2_idx;
    end else if (r_valid && !out_ready && !flush && wb_en && wb_addr != 5'd31) begin
      if (wb_addr == r_rn_idx) r_rdata1 <= wb_data;
      if (wb_addr == r_r2_idx) r_rdata2 <= wb_data;
    end
  end

  assign out_valid   = r_valid;
  assign out_pc      = r_pc;
  assign out_rdata1  = r_rdata1;
  assign out_rdata2  = r_rdata2;
  assign out_imm     = r_imm;
  assign out_rd      = r_rd;
  assign out_ctrl    = r_ctrl;
  assign out_illegal = r_illegal;

endmodule

// File: tb/tb_stage2_decode.sv
// Directed and randomized bench for stage2_decode against a mnemonic-level reference model.
module tb_stage2_decode;

  localparam int K_ADD = 0, K_SUB = 1, K_AND = 2, K_ORR = 3, K_ADDI = 4, K_SUBI = 5;
  localparam int K_LDUR = 6, K_STUR = 7, K_CBZ = 8, K_B = 9, K_ILL = 10;

  typedef struct packed {
    logic [31:0] instr;
    logic [9:0]  ctrl;
    logic [63:0] imm;
    logic        ill;
    logic [4:0]  rn;
    logic [4:0]  r2;
    logic        use_rn;
    logic        use_r2;
  } dec_t;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, flush, wb_en, ex_mem_read, out_valid, out_ready, out_illegal;
  logic [31:0] in_instr;
  logic [63:0] in_pc, wb_data, out_pc, out_rdata1, out_rdata2, out_imm;
  logic [4:0]  wb_addr, ex_rd, out_rd;
  logic [9:0]  out_ctrl;

  int n_checks = 0;
  int n_fail   = 0;

  dec_t        cur;
  logic        m_valid, m_ill;
  logic [63:0] m_pc, m_rd1, m_rd2, m_imm;
  logic [4:0]  m_rd, m_rn, m_r2;
  logic [9:0]  m_ctrl;
  logic [63:0] m_regs [32];

  stage2_decode dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .flush       (flush),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_rdata1  (out_rdata1),
    .out_rdata2  (out_rdata2),
    .out_imm     (out_imm),
    .out_rd      (out_rd),
    .out_ctrl    (out_ctrl),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Builds an instruction from its mnemonic and fields; expectations come from the ISA description.
  function automatic dec_t mk(int kind, int rm, int rn, int rd, int v);
    dec_t        d;
    logic [31:0] w;
    logic [31:0] op;
    d = '0;
    w = '0;
    case (kind)
      K_ADD, K_SUB, K_AND, K_ORR: begin
        op = (kind == K_ADD) ? 32'h458 : (kind == K_SUB) ? 32'h658 : (kind == K_AND) ? 32'h450 : 32'h550;
        w = (op << 21) | (32'(rm & 31) << 16) | (32'(rn & 31) << 5) | 32'(rd & 31);
        d.ctrl = 10'b0001000010; d.use_rn = 1'b1; d.use_r2 = 1'b1;
      end
      K_ADDI, K_SUBI: begin
        op = (kind == K_ADDI) ? 32'h244 : 32'h344;
        w = (op << 22) | (32'(v & 4095) << 10) | (32'(rn & 31) << 5) | 32'(rd & 31);
        d.ctrl = 10'b0101000010; d.imm = 64'(v & 4095); d.use_rn = 1'b1;
      end
      K_LDUR, K_STUR: begin
        op = (kind == K_LDUR) ? 32'h7C2 : 32'h7C0;
        w = (op << 21) | (32'(v & 511) << 12) | (32'(rn & 31) << 5) | 32'(rd & 31);
        d.ctrl = (kind == K_LDUR) ? 10'b0111100000 : 10'b1100010000;
        d.imm = 64'(longint'(v)); d.use_rn = 1'b1; d.use_r2 = (kind == K_STUR);
      end
      K_CBZ: begin
        w = (32'hB4 << 24) | (32'(v & 32'h7FFFF) << 5) | 32'(rd & 31);
        d.ctrl = 10'b1000001001; d.imm = 64'(longint'(v) * 4); d.use_r2 = 1'b1;
      end
      K_B: begin
        w = (32'h05 << 26) | 32'(v & 32'h3FFFFFF);
        d.ctrl = 10'b0000000100; d.imm = 64'(longint'(v) * 4);
      end
      default: begin
        w = 32'(v); d.ill = 1'b1;
      end
    endcase
    d.instr = w;
    d.rn    = w[9:5];
    d.r2    = d.ctrl[9] ? w[4:0] : w[20:16];
    return d;
  endfunction

  function automatic logic [63:0] mrd(input logic [4:0] a);
    if (a == 5'd31) return 64'd0;
    if (wb_en && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  task automatic set_in(input dec_t d, input logic [63:0] pc, input logic v);
    cur      = d;
    in_instr = d.instr;
    in_pc    = pc;
    in_valid = v;
  endtask

  // One clock: check in_ready, advance the model, then compare the registered bundle.
  task automatic tick();
    logic stall, exp_rdy;
    #1;
    stall = 1'b0;
`ifdef LEGV8_HAZARD_DETECT_EN
    stall = ex_mem_read && ex_rd != 5'd31 &&
            ((cur.use_rn && ex_rd == cur.rn) || (cur.use_r2 && ex_rd == cur.r2));
`endif
    exp_rdy = !reset && !flush && !stall && (!m_valid || out_ready);
    chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
    if (reset) begin
      m_valid = 0; m_pc = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_rd = 0; m_ctrl = 0;
      m_ill = 0; m_rn = 0; m_r2 = 0;
      for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
    end else begin
      if (flush) begin
        m_valid = 1'b0;
      end else if (in_valid && exp_rdy) begin
        m_valid = 1'b1; m_pc = in_pc; m_rd1 = mrd(cur.rn); m_rd2 = mrd(cur.r2);
        m_imm = cur.imm; m_rd = cur.instr[4:0]; m_ctrl = cur.ctrl; m_ill = cur.ill;
        m_rn = cur.rn; m_r2 = cur.r2;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end else if (m_valid && wb_en && wb_addr != 5'd31) begin
        if (wb_addr == m_rn) m_rd1 = wb_data;
        if (wb_addr == m_r2) m_rd2 = wb_data;
      end
      if (wb_en && wb_addr != 5'd31) m_regs[wb_addr] = wb_data;
    end
    @(posedge clk);
    #1;
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
    chk("out_pc", out_pc, m_pc);
    chk("out_rdata1", out_rdata1, m_rd1);
    chk("out_rdata2", out_rdata2, m_rd2);
    chk("out_imm", out_imm, m_imm);
    chk("out_rd", {59'd0, out_rd}, {59'd0, m_rd});
    chk("out_ctrl", {54'd0, out_ctrl}, {54'd0, m_ctrl});
    chk("out_illegal", {63'd0, out_illegal}, {63'd0, m_ill});
  endtask

  function automatic int rreg();
    return ($urandom_range(0, 9) == 0) ? 31 : int'($urandom_range(0, 7));
  endfunction

  initial begin
    dec_t d;
    int   kind, v;
    reset = 1'b1; flush = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    ex_mem_read = 1'b0; ex_rd = '0; out_ready = 1'b1;
    set_in(mk(K_ILL, 0, 0, 0, 0), 64'd0, 1'b0);
    m_valid = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rdy_after_reset", {63'd0, in_ready}, 64'd1);

    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 64'd5; tick();
    wb_addr = 5'd2; wb_data = 64'd7; tick();
    wb_en = 1'b0;

    d = mk(K_ADD, 2, 1, 3, 0);
    d.instr = 32'h8B020023;
    set_in(d, 64'h10, 1'b1); tick();
    chk("add_rdata1", out_rdata1, 64'd5);
    chk("add_rdata2", out_rdata2, 64'd7);
    chk("add_rd", {59'd0, out_rd}, 64'd3);
    chk("add_reg_write", {63'd0, out_ctrl[6]}, 64'd1);
    chk("add_pc", out_pc, 64'h10);

    set_in(mk(K_LDUR, 0, 2, 1, -8), 64'h14, 1'b1); tick();
    chk("ldur_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("ldur_ctrl", {61'd0, out_ctrl[8], out_ctrl[7], out_ctrl[5]}, 64'd7);

    set_in(mk(K_ADD, 2, 1, 3, 0), 64'h18, 1'b1);
    ex_mem_read = 1'b1; ex_rd = 5'd1;
    tick();
`ifdef LEGV8_HAZARD_DETECT_EN
    chk("stall_bubble", {63'd0, out_valid}, 64'd0);
    ex_mem_read = 1'b0;
    tick();
    chk("stall_release", {63'd0, out_valid}, 64'd1);
`else
    chk("no_interlock_accept", {63'd0, out_valid}, 64'd1);
    ex_mem_read = 1'b0;
`endif

    set_in(mk(K_ADD, 2, 1, 3, 0), 64'h1C, 1'b1); tick();
    in_valid = 1'b0; out_ready = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd2; wb_data = 64'h99; tick();
    chk("held_wb_rdata2", out_rdata2, 64'h99);
    wb_en = 1'b0; tick();
    chk("held_valid", {63'd0, out_valid}, 64'd1);

    flush = 1'b1;
    set_in(mk(K_SUB, 1, 2, 4, 0), 64'h20, 1'b1); tick();
    chk("flush_drop", {63'd0, out_valid}, 64'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; tick();

    set_in(mk(K_ILL, 0, 0, 0, -1), 64'h24, 1'b1); tick();
    chk("illegal_flag", {63'd0, out_illegal}, 64'd1);
    chk("illegal_ctrl", {54'd0, out_ctrl}, 64'd0);

    wb_en = 1'b1; wb_addr = 5'd31; wb_data = 64'h1234;
    set_in(mk(K_ADD, 31, 31, 0, 0), 64'h28, 1'b1); tick();
    wb_en = 1'b0; tick();
    chk("xzr_read", out_rdata1, 64'd0);

    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 64'hABC;
    set_in(mk(K_ADD, 5, 5, 6, 0), 64'h2C, 1'b1); tick();
    wb_en = 1'b0;
    chk("write_first", out_rdata1, 64'hABC);

    for (int n = 0; n < 300; n++) begin
      kind = int'($urandom_range(0, 10));
      case (kind)
        K_ADDI, K_SUBI: v = int'($urandom_range(0, 4095));
        K_LDUR, K_STUR: v = int'($urandom_range(0, 511)) - 256;
        K_CBZ:          v = int'($urandom_range(0, 32'h7FFFF)) - 32'h40000;
        K_B:            v = int'($urandom_range(0, 32'h3FFFFFF)) - 32'h2000000;
        K_ILL:          v = int'(32'hFFE00000 | ($urandom & 32'h1FFFFF));
        default:        v = 0;
      endcase
      set_in(mk(kind, rreg(), rreg(), rreg(), v), {$urandom, $urandom}, ($urandom_range(0, 3) != 0));
      out_ready   = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 15) == 0);
      wb_en       = $urandom_range(0, 1) == 1;
      wb_addr     = 5'(rreg());
      wb_data     = {$urandom, $urandom};
      ex_mem_read = ($urandom_range(0, 3) == 0);
      ex_rd       = 5'(rreg());
      tick();
    end

    flush = 1'b0; ex_mem_read = 1'b0; out_ready = 1'b1;
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 64'd5;
    set_in(mk(K_ADD, 2, 1, 3, 0), 64'h40, 1'b1); tick();
    wb_addr = 5'd2; wb_data = 64'd7; in_valid = 1'b0; out_ready = 1'b0; tick();
    wb_en = 1'b0; reset = 1'b1; tick();
    chk("reset_valid", {63'd0, out_valid}, 64'd0);
    reset = 1'b0; out_ready = 1'b1;
    set_in(mk(K_ADD, 2, 1, 3, 0), 64'h44, 1'b1); tick();
    chk("reset_cleared_x1", out_rdata1, 64'd0);
    chk("reset_cleared_x2", out_rdata2, 64'd0);
    in_valid = 1'b0; tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
